// File: rtl/spi_xfer_ctrl.sv
// SPI master sequencer: one command byte out MSB first, then eight bits of miso captured.
// Optional response self-check against the bit-reversed command under SPI_BITREV_CHECK_EN.
module spi_xfer_ctrl #(
  parameter int DIV = 2,
  parameter int GAP = 2
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [7:0] req_data,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic       busy,
  output logic       sck,
  output logic       ss,
  output logic       mosi,
  input  logic       miso,
`ifdef SPI_BITREV_CHECK_EN
  output logic       rsp_mismatch,
`endif
  output logic [2:0] dbg_state
);

  // Request and response ports both transfer on the rising clock edge where
  // valid && ready; valid never depends on ready, and held data stays stable.

  if (DIV < 1 || DIV > 255) begin : g_div_bad
    $fatal(1, "spi_xfer_ctrl: DIV must be in 1..255");
  end
  if (GAP < 1 || GAP > 255) begin : g_gap_bad
    $fatal(1, "spi_xfer_ctrl: GAP must be in 1..255");
  end

  localparam logic [7:0] DIV_LAST = 8'(DIV - 1);
  localparam logic [7:0] GAP_LAST = 8'(GAP - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_TX    = 3'd2,
    ST_RX    = 3'd3,
    ST_RESP  = 3'd4
  } state_t;

  state_t     r_state;
  logic [7:0] r_div_cnt;
  logic [3:0] r_bit_cnt;
  logic [7:0] r_gap_cnt;
  logic       r_hs_done;
  logic [7:0] r_tx_sh;
  logic [7:0] r_rx_sh;
  logic       r_sck;
  logic       r_ss;
  logic       r_mosi;
  logic       r_req_ready;
  logic       r_rsp_valid;
  logic [7:0] r_rsp_data;
  logic       r_busy;

  logic w_div_done;
  logic w_hs;
  logic w_gap_ok;
  logic w_accept;
  logic w_load;

  assign w_div_done = (r_div_cnt == DIV_LAST);
  assign w_hs       = r_rsp_valid && rsp_ready;
  assign w_gap_ok   = (r_gap_cnt >= GAP_LAST);
  assign w_accept   = (r_state == ST_IDLE) && req_valid && r_req_ready;
  // One settling cycle after the last sampling fall, then the response is published.
  assign w_load     = (r_state == ST_RX) && (r_bit_cnt == 4'd8);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_div_cnt   <= 8'd0;
      r_bit_cnt   <= 4'd0;
      r_gap_cnt   <= 8'd0;
      r_hs_done   <= 1'b0;
      r_tx_sh     <= 8'd0;
      r_rx_sh     <= 8'd0;
      r_sck       <= 1'b0;
      r_ss        <= 1'b1;
      r_mosi      <= 1'b0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= 8'd0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_div_cnt <= 8'd0;
          r_bit_cnt <= 4'd0;
          if (w_accept) begin
            r_tx_sh     <= {req_data[6:0], 1'b0};
            r_mosi      <= req_data[7];
            r_rx_sh     <= 8'd0;
            r_ss        <= 1'b0;
            r_sck       <= 1'b0;
            r_req_ready <= 1'b0;
            r_busy      <= 1'b1;
            r_state     <= ST_SETUP;
          end
        end

        ST_SETUP: begin
          if (w_div_done) begin
            r_div_cnt <= 8'd0;
            r_state   <= ST_TX;
          end else begin
            r_div_cnt <= r_div_cnt + 8'd1;
          end
        end

        ST_TX, ST_RX: begin
          if (w_load) begin
            r_rsp_data  <= r_rx_sh;
            r_rsp_valid <= 1'b1;
            r_ss        <= 1'b1;
            r_gap_cnt   <= 8'd0;
            r_hs_done   <= 1'b0;
            r_state     <= ST_RESP;
          end else if (!w_div_done) begin
            r_div_cnt <= r_div_cnt + 8'd1;
          end else begin
            r_div_cnt <= 8'd0;
            if (!r_sck) begin
              r_sck <= 1'b1;
            end else begin
              r_sck     <= 1'b0;
              r_bit_cnt <= r_bit_cnt + 4'd1;
              if (r_state == ST_TX) begin
                r_mosi  <= r_tx_sh[7];
                r_tx_sh <= {r_tx_sh[6:0], 1'b0};
                if (r_bit_cnt == 4'd7) begin
                  r_mosi    <= 1'b0;
                  r_bit_cnt <= 4'd0;
                  r_state   <= ST_RX;
                end
              end else begin
                r_rx_sh <= {r_rx_sh[6:0], miso};
              end
            end
          end
        end

        ST_RESP: begin
          // Handshake and inter-transfer gap are tracked independently.
          if (!w_gap_ok) begin
            r_gap_cnt <= r_gap_cnt + 8'd1;
          end
          if (w_hs) begin
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_hs_done   <= 1'b1;
          end
          if ((w_hs || r_hs_done) && w_gap_ok) begin
            r_req_ready <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef SPI_BITREV_CHECK_EN
  logic [7:0] r_cmd;
  logic [7:0] w_cmd_rev;
  logic       r_mismatch;

  always_comb begin
    w_cmd_rev = 8'd0;
    for (int i = 0; i < 8; i++) begin
      w_cmd_rev[i] = r_cmd[7 - i];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cmd      <= 8'd0;
      r_mismatch <= 1'b0;
    end else begin
      if (w_accept) begin
        r_cmd <= req_data;
      end
      if (w_load) begin
        r_mismatch <= (r_rx_sh != w_cmd_rev);
      end
    end
  end

  assign rsp_mismatch = r_mismatch;
`endif

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign busy      = r_busy;
  assign sck       = r_sck;
  assign ss        = r_ss;
  assign mosi      = r_mosi;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Directed + randomized bench for spi_xfer_ctrl with a bit-reversing SPI slave model.
// Build with SPI_BITREV_CHECK_EN defined to also check rsp_mismatch.
module tb_spi_xfer_ctrl;

  localparam int DIV = 2;
  localparam int GAP = 4;
  localparam int LAT = 1 + 33 * DIV;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       req_valid;
  logic       req_ready;
  logic [7:0] req_data;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic       busy;
  logic       sck;
  logic       ss;
  logic       mosi;
  logic       miso;
  logic [2:0] dbg_state;
`ifdef SPI_BITREV_CHECK_EN
  logic       rsp_mismatch;
`endif

  spi_xfer_ctrl #(.DIV(DIV), .GAP(GAP)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_data     (req_data),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .busy         (busy),
    .sck          (sck),
    .ss           (ss),
    .mosi         (mosi),
    .miso         (miso),
`ifdef SPI_BITREV_CHECK_EN
    .rsp_mismatch (rsp_mismatch),
`endif
    .dbg_state    (dbg_state)
  );

  // ---------------- clock / reset block ----------------
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc++;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  // ---------------- counters and scoreboard ----------------
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] exp_q[$];
  int         acc_cyc;
  logic [7:0] acc_data;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] rev8(input logic [7:0] d);
    logic [7:0] r;
    r = {<<{d}};
    return r;
  endfunction

  // ---------------- slave model: receive 8 bits, answer with their reversal ----------------
  int         sl_cnt = 0;
  logic [7:0] sl_rx = 8'd0;
  logic [7:0] sl_reply = 8'd0;
  logic       sl_force_en = 1'b0;
  logic [7:0] sl_force_val = 8'd0;

  initial miso = 1'b0;

  always @(posedge sck or posedge ss) begin
    if (ss) begin
      sl_cnt = 0;
      miso   = 1'b0;
    end else begin
      if (sl_cnt < 8) sl_rx = {sl_rx[6:0], mosi};
      if (sl_cnt == 7) sl_reply = sl_force_en ? sl_force_val : rev8(sl_rx);
      if (sl_cnt >= 8 && sl_cnt < 16) miso = sl_reply[15 - sl_cnt];
      sl_cnt++;
    end
  end

  // ---------------- bus monitors ----------------
  int         mon_rises = 0;
  logic [7:0] mon_mosi = 8'd0;
  int         bad_rise = 0;
  int         bad_fall = 0;
  int         ss_run = 0;
  int         last_run = 0;

  always @(posedge sck or negedge ss) begin
    if (!sck) begin
      mon_rises = 0;
      mon_mosi  = 8'd0;
    end else if (ss) begin
      if (reset_n) bad_rise++;
    end else begin
      mon_rises++;
      if (mon_rises <= 8) mon_mosi = {mon_mosi[6:0], mosi};
    end
  end

  always @(negedge sck) if (ss && reset_n) bad_fall++;

  always @(posedge clock) begin
    if (ss) ss_run++;
    else begin
      if (ss_run > 0) last_run = ss_run;
      ss_run = 0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic accept(input logic [7:0] d, input bit keep_valid);
    int n;
    @(negedge clock);
    req_valid = 1'b1;
    req_data  = d;
    n = 0;
    while (!req_ready && n < 500) begin
      @(negedge clock);
      n++;
    end
    check("accept_ready_timeout", 32'(n < 500), 32'd1);
    @(posedge clock);
    #1;
    acc_cyc  = cyc;
    acc_data = d;
    exp_q.push_back(sl_force_en ? sl_force_val : rev8(d));
    check("acc_busy", 32'(busy), 32'd1);
    check("acc_ss_low", 32'(ss), 32'd0);
    check("acc_req_ready", 32'(req_ready), 32'd0);
    if (!keep_valid) begin
      @(negedge clock);
      req_valid = 1'b0;
    end
  endtask

  task automatic collect(input int bp);
    int n;
    logic [7:0] exp;
    rsp_ready = (bp == 0);
    n = 0;
    do begin
      @(posedge clock);
      #1;
      n++;
    end while (!rsp_valid && n < 2000);
    check("rsp_timeout", 32'(rsp_valid), 32'd1);
    if (!rsp_valid) begin
      rsp_ready = 1'b0;
      return;
    end
    exp = exp_q.pop_front();
    check("rsp_latency", 32'(cyc - acc_cyc), 32'(LAT));
    check("rsp_data", 32'(rsp_data), 32'(exp));
    check("sck_rises", 32'(mon_rises), 32'd16);
    check("mosi_pattern", 32'(mon_mosi), 32'(acc_data));
    check("rsp_ss_high", 32'(ss), 32'd1);
    check("rsp_busy", 32'(busy), 32'd1);
`ifdef SPI_BITREV_CHECK_EN
    check("rsp_mismatch", 32'(rsp_mismatch), 32'(exp != rev8(acc_data)));
`endif
    if (bp > 0) begin
      repeat (bp) begin
        @(negedge clock);
        check("hold_valid", 32'(rsp_valid), 32'd1);
        check("hold_data", 32'(rsp_data), 32'(exp));
        check("hold_ss", 32'(ss), 32'd1);
        check("hold_sck", 32'(sck), 32'd0);
        check("hold_req_ready", 32'(req_ready), 32'd0);
      end
      @(negedge clock);
      rsp_ready = 1'b1;
    end
    @(posedge clock);
    #1;
    check("post_hs_valid", 32'(rsp_valid), 32'd0);
    check("post_hs_busy", 32'(busy), 32'd0);
    // Handshake lands bp+1 cycles after ss rose; IDLE needs GAP of them.
    check("post_hs_req_ready", 32'(req_ready), 32'(bp + 1 >= GAP));
    rsp_ready = 1'b0;
  endtask

  task automatic xfer(input logic [7:0] d, input int bp);
    accept(d, 1'b0);
    collect(bp);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    int hi;
    reset_n   = 1'b0;
    req_valid = 1'b0;
    req_data  = 8'd0;
    rsp_ready = 1'b0;

    // Reset holds outputs regardless of request activity.
    repeat (4) begin
      @(negedge clock);
      req_valid = 1'($urandom_range(0, 1));
      req_data  = 8'($urandom_range(0, 255));
      #1;
      check("rst_sck", 32'(sck), 32'd0);
      check("rst_ss", 32'(ss), 32'd1);
      check("rst_req_ready", 32'(req_ready), 32'd1);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    end
    check("rst_mosi", 32'(mosi), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    @(negedge clock);
    req_valid = 1'b0;
    reset_n   = 1'b1;
    repeat (2) @(negedge clock);

    // Basic transfer with the reversing slave.
    xfer(8'h01, 0);

    // Response backpressure.
    xfer(8'h6B, 20);

    // Back-to-back with req_valid held high.
    accept(8'h5A, 1'b1);
    collect(0);
    accept(8'hA5, 1'b0);
    collect(0);
    check("b2b_ss_gap", 32'(last_run >= GAP), 32'd1);

    // Randomized transfers with random backpressure.
    for (int i = 0; i < 6; i++) begin
      xfer(8'($urandom_range(0, 255)), $urandom_range(0, 6));
    end

    // Reset mid-transfer at the 10th sck rise.
    accept(8'hC3, 1'b0);
    n = 0;
    while (mon_rises < 10 && n < 500) begin
      @(posedge clock);
      #1;
      n++;
    end
    check("abort_reach_rise10", 32'(mon_rises), 32'd10);
    reset_n = 1'b0;
    #1;
    check("abort_ss", 32'(ss), 32'd1);
    check("abort_sck", 32'(sck), 32'd0);
    check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    hi = 0;
    repeat (80) begin
      @(negedge clock);
      if (rsp_valid) hi++;
    end
    check("abort_no_rsp", 32'(hi), 32'd0);
    xfer(8'h3C, 0);

    // Slave forced to a wrong reply, then a correct one.
    sl_force_en  = 1'b1;
    sl_force_val = 8'h00;
    xfer(8'h01, 0);
    sl_force_en  = 1'b0;
    xfer(8'h01, 0);

    // ---------------- final report ----------------
    repeat (10) @(negedge clock);
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    check("sck_rise_while_ss_high", 32'(bad_rise), 32'd0);
    check("sck_fall_while_ss_high", 32'(bad_fall), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
